pll_lock_supervisor: RTL and testbench

Supervises the fabric PLL from the free-running reference-clock domain. It drives the PLL reset, waits for `locked`, and qualifies lock as stable. It then releases a bank of downstream resets in a fixed staged order. On timeout or loss of lock it re-resets the PLL, holds all downstream logic in reset, and counts each event.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 170 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } pll_state_e;

   // One extra bit of headroom over the longest interval the shared timer must cover.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer for signals arriving from another clock domain.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies lock, then releases downstream resets in stages;
// any timeout or lock loss sends everything back through a fresh PLL reset.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int NUM_RST        = 3,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 1000000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGE_GAP      = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               locked_i,
   output logic               pll_rst_o,
   output logic [NUM_RST-1:0] rst_out_o,
   output logic               ready_o,
   output logic [7:0]         lock_loss_count_o,
   output logic [7:0]         timeout_count_o
);

   localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP, PLL_RST_CYCLES);
   localparam int SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

   localparam logic [CW-1:0] TIMER_ONE    = CW'(1);
   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
   localparam logic [SW-1:0] STAGE_ONE    = SW'(1);
   localparam logic [SW-1:0] STAGE_LAST   = SW'(NUM_RST - 1);

   pll_state_e         state_q, state_d;
   logic [CW-1:0]      timer_q, timer_d;
   logic [SW-1:0]      stage_q, stage_d;
   logic               pllRst_q, pllRst_d;
   logic               ready_q, ready_d;
   logic [NUM_RST-1:0] rstOut_q, rstOut_d;
   logic [7:0]         lossCount_q, lossCount_d;
   logic [7:0]         timeoutCount_q, timeoutCount_d;
   logic               lockedSync;
   logic               lossEvent;
   logic               timeoutEvent;

   sync_2ff u_lockSync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (locked_i),
      .q_o   (lockedSync)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= PLL_RESET;
         timer_q        <= '0;
         stage_q        <= '0;
         pllRst_q       <= 1'b1;
         rstOut_q       <= '1;
         ready_q        <= 1'b0;
         lossCount_q    <= '0;
         timeoutCount_q <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         stage_q        <= stage_d;
         pllRst_q       <= pllRst_d;
         rstOut_q       <= rstOut_d;
         ready_q        <= ready_d;
         lossCount_q    <= lossCount_d;
         timeoutCount_q <= timeoutCount_d;
      end
   end

   // The timer counts up within each state; entering release also covers the
   // degenerate single-cycle qualification and single-output cases.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      stage_d      = stage_q;
      lossEvent    = 1'b0;
      timeoutEvent = 1'b0;
      unique case (state_q)
         PLL_RESET: begin
            if (timer_q == PLL_RST_LAST) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         WAIT_LOCK: begin
            if (lockedSync) begin
               timer_d = TIMER_ONE;
               stage_d = '0;
               if (STABLE_CYCLES == 1) begin
                  timer_d = '0;
                  state_d = (NUM_RST == 1) ? RUN : RELEASE;
               end else begin
                  state_d = STABLE;
               end
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d      = PLL_RESET;
               timer_d      = '0;
               timeoutEvent = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         STABLE: begin
            if (!lockedSync) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_LAST) begin
               timer_d = '0;
               stage_d = '0;
               state_d = (NUM_RST == 1) ? RUN : RELEASE;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         RELEASE: begin
            if (!lockedSync) begin
               state_d   = PLL_RESET;
               timer_d   = '0;
               stage_d   = '0;
               lossEvent = 1'b1;
            end else if (timer_q == GAP_LAST) begin
               timer_d = '0;
               stage_d = stage_q + STAGE_ONE;
               if (stage_d == STAGE_LAST) state_d = RUN;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         RUN: begin
            if (!lockedSync) begin
               state_d   = PLL_RESET;
               timer_d   = '0;
               stage_d   = '0;
               lossEvent = 1'b1;
            end
         end
         default: begin
            state_d = PLL_RESET;
            timer_d = '0;
            stage_d = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register on the same edge as the transition.
   always_comb begin
      pllRst_d = (state_d == PLL_RESET);
      ready_d  = (state_d == RUN);
      rstOut_d = '1;
      for (int i = 0; i < NUM_RST; i++) begin
         rstOut_d[i] = !((state_d == RUN) || ((state_d == RELEASE) && (i <= int'(stage_d))));
      end
      lossCount_d    = (lossEvent && (lossCount_q != 8'hFF)) ? lossCount_q + 8'd1 : lossCount_q;
      timeoutCount_d = (timeoutEvent && (timeoutCount_q != 8'hFF)) ? timeoutCount_q + 8'd1
                                                                  : timeoutCount_q;
   end

   assign pll_rst_o         = pllRst_q;
   assign rst_out_o         = rstOut_q;
   assign ready_o           = ready_q;
   assign lock_loss_count_o = lossCount_q;
   assign timeout_count_o   = timeoutCount_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: per-cycle vector tables plus timeout and reset sequences.
module tb_pll_lock_supervisor;

   logic       clk;
   logic       rst;
   logic       locked;
   logic       pllRst;
   logic [2:0] rstOut;
   logic       ready;
   logic [7:0] lossCount;
   logic [7:0] timeoutCount;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       locked;
      logic       pllRst;
      logic [2:0] rstOut;
      logic       ready;
      logic [7:0] lossCount;
      logic [7:0] timeoutCount;
   } vec_t;

   vec_t vecs[$];

   pll_lock_supervisor #(
      .NUM_RST        (3),
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (20),
      .STABLE_CYCLES  (8),
      .STAGE_GAP      (3)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .locked_i          (locked),
      .pll_rst_o         (pllRst),
      .rst_out_o         (rstOut),
      .ready_o           (ready),
      .lock_loss_count_o (lossCount),
      .timeout_count_o   (timeoutCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVecs(input int n, input logic r, input logic l, input logic p,
                          input logic [2:0] ro, input logic rd, input logic [7:0] ll);
      vec_t v;
      v.rst          = r;
      v.locked       = l;
      v.pllRst       = p;
      v.rstOut       = ro;
      v.ready        = rd;
      v.lossCount    = ll;
      v.timeoutCount = 8'd0;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic r, input logic l);
      rst    = r;
      locked = l;
   endtask

   // Inputs change at the falling edge; outputs are sampled at the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic p, input logic [2:0] ro,
                              input logic rd, input logic [7:0] ll, input logic [7:0] to);
      checks++;
      if ({pllRst, rstOut, ready, lossCount, timeoutCount} !== {p, ro, rd, ll, to}) begin
         errors++;
         $display("[TB] FAIL %s: got pll_rst=%b rst_out=%b ready=%b loss=%0d timeout=%0d, want pll_rst=%b rst_out=%b ready=%b loss=%0d timeout=%0d",
                  name, pllRst, rstOut, ready, lossCount, timeoutCount, p, ro, rd, ll, to);
      end
   endtask

   task automatic waitReady(input string name, input int budget);
      int n;
      n = 0;
      while (!ready && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!ready) begin
         errors++;
         $display("[TB] FAIL %s: ready=%b after %0d cycles, want 1", name, ready, budget);
      end
   endtask

   initial begin
      int expT;
      applyStimulus(1'b1, 1'b0);

      // Sequence A: lock from cycle 10, loss in RUN, relock, loss after 3'b100.
      addVecs(1, 1, 0, 1, 3'b111, 0, 0);
      addVecs(3, 0, 0, 1, 3'b111, 0, 0);
      addVecs(6, 0, 0, 0, 3'b111, 0, 0);
      addVecs(9, 0, 1, 0, 3'b111, 0, 0);
      addVecs(3, 0, 1, 0, 3'b110, 0, 0);
      addVecs(3, 0, 1, 0, 3'b100, 0, 0);
      addVecs(3, 0, 1, 0, 3'b000, 1, 0);
      addVecs(2, 0, 0, 0, 3'b000, 1, 0);
      addVecs(4, 0, 0, 1, 3'b111, 0, 1);
      addVecs(2, 0, 0, 0, 3'b111, 0, 1);
      addVecs(9, 0, 1, 0, 3'b111, 0, 1);
      addVecs(3, 0, 1, 0, 3'b110, 0, 1);
      addVecs(2, 0, 0, 0, 3'b100, 0, 1);
      addVecs(4, 0, 0, 1, 3'b111, 0, 2);
      addVecs(2, 0, 0, 0, 3'b111, 0, 2);
      // Sequence B: two-cycle dropout while qualifying at counter 5 restarts T0 at cycle 19.
      addVecs(1, 1, 0, 1, 3'b111, 0, 0);
      addVecs(3, 0, 0, 1, 3'b111, 0, 0);
      addVecs(6, 0, 0, 0, 3'b111, 0, 0);
      addVecs(5, 0, 1, 0, 3'b111, 0, 0);
      addVecs(2, 0, 0, 0, 3'b111, 0, 0);
      addVecs(9, 0, 1, 0, 3'b111, 0, 0);
      addVecs(3, 0, 1, 0, 3'b110, 0, 0);
      addVecs(3, 0, 1, 0, 3'b100, 0, 0);
      addVecs(2, 0, 1, 0, 3'b000, 1, 0);

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst, vecs[k].locked);
         tick();
         checkOutput($sformatf("vec %0d", k), vecs[k].pllRst, vecs[k].rstOut, vecs[k].ready,
                     vecs[k].lossCount, vecs[k].timeoutCount);
      end

      // Lock never arrives: PLL reset every 24 cycles, timeout count saturates at 255.
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("timeout reset", 1, 3'b111, 0, 0, 0);
      applyStimulus(1'b0, 1'b0);
      for (int n = 1; n <= 260; n++) begin
         repeat (23) tick();
         expT = (n - 1 > 255) ? 255 : n - 1;
         checkOutput($sformatf("timeout %0d before", n), 0, 3'b111, 0, 0, 8'(expT));
         tick();
         expT = (n > 255) ? 255 : n;
         checkOutput($sformatf("timeout %0d pulse", n), 1, 3'b111, 0, 0, 8'(expT));
      end

      // Lock after saturation, lose it in RUN, relock, then reset from RUN.
      applyStimulus(1'b0, 1'b1);
      waitReady("first run", 100);
      checkOutput("first run outputs", 0, 3'b000, 1, 0, 255);
      applyStimulus(1'b0, 1'b0);
      repeat (2) tick();
      checkOutput("run drop +2", 0, 3'b000, 1, 0, 255);
      tick();
      checkOutput("run drop +3", 1, 3'b111, 0, 1, 255);
      applyStimulus(1'b0, 1'b1);
      waitReady("relock run", 100);
      checkOutput("relock outputs", 0, 3'b000, 1, 1, 255);
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("reset in run", 1, 3'b111, 0, 0, 0);
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("after reset", 1, 3'b111, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
